// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, counter width.
package muldiv_pkg;

  // Op encodings; Op[0] selects divide, Op[1] selects signed
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // FSM state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Iteration counter width for the default 32-bit datapath
  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF + 1);

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Shared 2*WIDTH accumulator with one shift-add (multiply) or one restoring
// step (divide) per enable. Accumulator layout is {upper, lower} for both:
// multiply {partial product, remaining multiplier}, divide {remainder, quotient}.
module muldiv_core import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_load_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_step,
  output logic [2*WIDTH-1:0] o_acc_next
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_div;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_div_next;

  // One iteration of either algorithm, selected by the latched mode
  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
    w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    w_ge       = (w_rem_sh >= {1'b0, r_opnd});
    // When w_ge holds the difference is below the divisor, so W bits suffice
    w_sub      = w_rem_sh[WIDTH-1:0] - r_opnd;
    w_div_next = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                      : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    o_acc_next = r_div ? w_div_next : w_mul_next;
  end

  // Operand capture on load, one step per enable otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_opnd <= '0;
      r_div  <= 1'b0;
    end else if (i_load) begin
      r_acc  <= i_load_div ? {{WIDTH{1'b0}}, i_a} : {{WIDTH{1'b0}}, i_b};
      r_opnd <= i_load_div ? i_b : i_a;
      r_div  <= i_load_div;
    end else if (i_step) begin
      r_acc  <= o_acc_next;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. FSM, iteration counter, HI/LO,
// MTHI/MTLO path and sign handling live here; the datapath is muldiv_core.
// Optional signed ops (Op 10/11) enabled by defining MULDIV_SIGNED_EN.
module mult_div_unit import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MtHi,
  input  logic             MtLo,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int unsigned LP_CNT_W = $clog2(WIDTH + 1);

  logic [1:0]          r_state;
  logic [LP_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic                r_div_zero;
  logic                r_b_zero;

  logic                w_start;
  logic                w_op_div;
  logic                w_last;
  logic [WIDTH-1:0]    w_a_mag;
  logic [WIDTH-1:0]    w_b_mag;
  logic [2*WIDTH-1:0]  w_acc_next;
  logic [WIDTH-1:0]    w_res_hi;
  logic [WIDTH-1:0]    w_res_lo;

  assign w_start  = (r_state == S_IDLE) && Start;
  assign w_op_div = op_is_div(Op);
  assign w_last   = ((r_state == S_MUL) || (r_state == S_DIV)) &&
                    (r_cnt == LP_CNT_W'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
  logic w_signed;
  logic r_neg_q;
  logic r_neg_r;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_signed = (Op == OP_MULT) || (Op == OP_DIV);

  // Magnitudes go to the core; signs are remembered for the final fix-up
  always_comb begin
    w_a_mag = (w_signed && A[WIDTH-1]) ? -A : A;
    w_b_mag = (w_signed && B[WIDTH-1]) ? -B : B;
  end

  // Latch result signs at Start: quotient/product from A^B, remainder from A
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_start) begin
      r_neg_q <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
      r_neg_r <= w_signed && A[WIDTH-1];
    end
  end

  // Sign fix-up on the final iteration so HI/LO are correct from DONE onward
  always_comb begin
    w_prod_neg = -w_acc_next;
    if (r_state == S_DIV) begin
      w_res_lo = r_neg_q ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
      w_res_hi = r_neg_r ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];
    end else begin
      w_res_lo = r_neg_q ? w_prod_neg[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
      w_res_hi = r_neg_q ? w_prod_neg[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];
    end
  end
`else
  // Unsigned only: operands pass straight through
  always_comb begin
    w_a_mag  = A;
    w_b_mag  = B;
    w_res_hi = w_acc_next[2*WIDTH-1:WIDTH];
    w_res_lo = w_acc_next[WIDTH-1:0];
  end
`endif

  muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_load     (w_start),
    .i_load_div (w_op_div),
    .i_a        (w_a_mag),
    .i_b        (w_b_mag),
    .i_step     (Busy),
    .o_acc_next (w_acc_next)
  );

  // FSM, iteration counter, HI/LO and DivZero
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
      r_b_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state    <= w_op_div ? S_DIV : S_MUL;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            r_b_zero   <= (B == '0);
          end else begin
            if (MtHi) r_hi <= A;
            if (MtLo) r_lo <= A;
          end
        end
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state    <= S_DONE;
            r_cnt      <= '0;
            r_hi       <= w_res_hi;
            r_lo       <= w_res_lo;
            r_div_zero <= (r_state == S_DIV) && r_b_zero;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign Busy    = (r_state == S_MUL) || (r_state == S_DIV);
  assign Done    = (r_state == S_DONE);
  assign DivZero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table of directed vectors plus
// hand-written sequences for MT writes, Start-while-busy and mid-op reset.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         MtHi;
  logic         MtLo;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Busy;
  logic         Done;
  logic         DivZero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  mult_div_unit #(
    .WIDTH(W)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .MtHi    (MtHi),
    .MtLo    (MtLo),
    .Hi      (Hi),
    .Lo      (Lo),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op, check the busy window, the Done cycle and the result
  task automatic run_vec(input vec_t v);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic        busy_ok;
    old_hi  = Hi;
    old_lo  = Lo;
    busy_ok = 1'b1;
    @(negedge Clk);
    Start = 1'b1; Op = v.op; A = v.a; B = v.b;
    @(posedge Clk); #1;
    // Scramble operands: the running op must use the captured values
    Start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0;
    for (int k = 0; k < W; k++) begin
      if (!(Busy === 1'b1 && Done === 1'b0 && Hi === old_hi && Lo === old_lo)) busy_ok = 1'b0;
      @(posedge Clk); #1;
    end
    check($sformatf("%s busy window", v.name), {31'b0, busy_ok}, 32'd1);
    check($sformatf("%s done", v.name), {31'b0, Done}, 32'd1);
    check($sformatf("%s busy at done", v.name), {31'b0, Busy}, 32'd0);
    check($sformatf("%s hi", v.name), Hi, v.hi);
    check($sformatf("%s lo", v.name), Lo, v.lo);
    check($sformatf("%s divzero", v.name), {31'b0, DivZero}, {31'b0, v.dz});
    @(posedge Clk); #1;
    check($sformatf("%s done pulse ends", v.name), {31'b0, Done}, 32'd0);
  endtask

  initial begin
    logic busy_seen;
    logic done_seen;
    int   cyc;

    vecs[0] = '{"multu 7x6",      2'b00, 32'd7,        32'd6,        32'd0,        32'd42,       1'b0};
    vecs[1] = '{"multu max",      2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{"divu 100/7",     2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3] = '{"divu 5/0",       2'b01, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[4] = '{"divu shift",     2'b01, 32'h12345678, 32'h00010000, 32'h5678,     32'h1234,     1'b0};
    vecs[5] = '{"multu 2^32",     2'b00, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};
    vecs[6] = '{"mult 3x5",       2'b10, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0};
`ifdef MULDIV_SIGNED_EN
    vecs[7] = '{"mult -3x5",      2'b10, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[8] = '{"div -7/2",       2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
`else
    vecs[7] = '{"mult -3x5 uns",  2'b10, 32'hFFFFFFFD, 32'd5,        32'd4,        32'hFFFFFFF1, 1'b0};
    vecs[8] = '{"div -7/2 uns",   2'b11, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 1'b0};
`endif
    vecs[9] = '{"divu 3/10",      2'b01, 32'd3,        32'd10,       32'd3,        32'd0,        1'b0};

    Rst = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0; MtHi = 1'b0; MtLo = 1'b0;
    #2 Rst = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk); Rst = 1'b0;
    #1;
    check("reset hi", Hi, 32'd0);
    check("reset lo", Lo, 32'd0);
    check("reset busy", {31'b0, Busy}, 32'd0);
    check("reset done", {31'b0, Done}, 32'd0);
    check("reset divzero", {31'b0, DivZero}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // MTHI then MTLO, then both together
    @(negedge Clk); MtHi = 1'b1; A = 32'h1234;
    @(negedge Clk); MtHi = 1'b0; MtLo = 1'b1; A = 32'h5678;
    @(negedge Clk); MtLo = 1'b0;
    check("mthi", Hi, 32'h1234);
    check("mtlo", Lo, 32'h5678);
    MtHi = 1'b1; MtLo = 1'b1; A = 32'hABCD;
    @(negedge Clk); MtHi = 1'b0; MtLo = 1'b0;
    check("mt both hi", Hi, 32'hABCD);
    check("mt both lo", Lo, 32'hABCD);

    // Start with MtHi in IDLE, then Start/MT during busy: all dropped
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; A = 32'd2; B = 32'd3; MtHi = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; MtHi = 1'b0; cyc = 1;
    check("start beats mthi", Hi, 32'hABCD);
    repeat (4) begin @(posedge Clk); #1; cyc++; end
    @(negedge Clk);
    Start = 1'b1; Op = 2'b01; A = 32'd1000; B = 32'd3; MtHi = 1'b1; MtLo = 1'b1;
    @(posedge Clk); #1; cyc++;
    Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    while (Done !== 1'b1 && cyc < W + 10) begin @(posedge Clk); #1; cyc++; end
    check("busy start done cycle", cyc, W + 1);
    check("busy start hi", Hi, 32'd0);
    check("busy start lo", Lo, 32'd6);
    busy_seen = 1'b0;
    repeat (40) begin @(posedge Clk); #1; if (Busy !== 1'b0) busy_seen = 1'b1; end
    check("no queued op", {31'b0, busy_seen}, 32'd0);
    check("no queued op lo", Lo, 32'd6);

    // Reset in the middle of a divide
    @(negedge Clk);
    Start = 1'b1; Op = 2'b01; A = 32'd100; B = 32'd7;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (10) begin @(posedge Clk); #1; end
    check("pre-reset busy", {31'b0, Busy}, 32'd1);
    Rst = 1'b1;
    #1;
    check("abort hi", Hi, 32'd0);
    check("abort lo", Lo, 32'd0);
    check("abort busy", {31'b0, Busy}, 32'd0);
    @(negedge Clk); Rst = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin @(posedge Clk); #1; if (Done !== 1'b0 || Busy !== 1'b0) done_seen = 1'b1; end
    check("no done after abort", {31'b0, done_seen}, 32'd0);

    // Unit works again after the abort
    run_vec(vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
